// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one RAM port between icache and dcache (dcache first), one word per grant.
// Define CACHE_ARB_FAIRNESS_EN to add a dcache streak counter that forces an icache grant.
module cache_mem_arbiter #(
    parameter int MAX_DSTREAK = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready,
    output logic [1:0]  dbg_state_o
);

    // Handshake: a requester raises its request and holds address/data stable until its
    // wait output goes low for one cycle; that cycle is the completion. Dropping the request
    // earlier aborts the access with no ack.

    if (MAX_DSTREAK < 1 || MAX_DSTREAK > 15) begin : g_bad_max_dstreak
        $error("cache_mem_arbiter: MAX_DSTREAK must be in 1..15");
    end

    // Encoding is visible on dbg_state_o: IDLE=0, IGRANT=1, DGRANT=2.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   d_req;
    logic   i_done;
    logic   d_done;
    logic   force_i;

    assign d_req       = dREN | dWEN;
    assign dbg_state_o = state_q;

    always_comb begin
        i_done = (state_q == IGRANT) && iREN && ram_ready;
        d_done = (state_q == DGRANT) && d_req && ram_ready;
    end

`ifdef CACHE_ARB_FAIRNESS_EN
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

    logic [3:0] streak_q, streak_d;

    // Counts dcache completions that happened while icache was kept waiting.
    always_comb begin
        streak_d = streak_q;
        if (i_done || (state_q == IDLE && !iREN)) begin
            streak_d = 4'd0;
        end else if (d_done && iREN && streak_q != STREAK_MAX) begin
            streak_d = streak_q + 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            streak_q <= 4'd0;
        end else begin
            streak_q <= streak_d;
        end
    end

    assign force_i = (streak_q == STREAK_MAX) && iREN;
`else
    assign force_i = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (d_req && !force_i) begin
                    state_d = DGRANT;
                end else if (iREN) begin
                    state_d = IGRANT;
                end
            end
            IGRANT: begin
                // Leave on completion or when icache withdraws (abort).
                if (!iREN || ram_ready) begin
                    state_d = IDLE;
                end
            end
            DGRANT: begin
                if (!d_req || ram_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = 32'd0;
        dload    = 32'd0;
        case (state_q)
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (i_done) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            DGRANT: begin
                // A simultaneous read and write request is served as a write.
                ramaddr  = daddr;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramstore = dWEN ? dstore : 32'd0;
                if (d_done) begin
                    dwait = 1'b0;
                    dload = ramload;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: vector table, corner sequences, random transactions.
module tb_cache_mem_arbiter;

  localparam int MAX    = 4;
  localparam int BUDGET = 40;
`ifdef CACHE_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN, ram_ready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic [1:0]  dbg_state;

  always #5 CLK = ~CLK;

  cache_mem_arbiter #(.MAX_DSTREAK(MAX)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        is_d;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] load;
  } exp_t;

  exp_t exp_q[$];

  // kind: 0=I read, 1=D read, 2=D write, 3=D read+write, 4=I+D read, 5=I+D write
  typedef struct {
    int          kind;
    logic [31:0] ia, da, dd, ird, drd;
    int          lat;
    logic        exp_first_d;
    int          exp_first;
    int          exp_total;
    logic [31:0] exp_iload, exp_dload;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ramREN"}, ramREN, 0);
    chk({tag, "_ramWEN"}, ramWEN, 0);
    chk({tag, "_ramaddr"}, ramaddr, 0);
    chk({tag, "_ramstore"}, ramstore, 0);
    chk({tag, "_iwait"}, iwait, 1);
    chk({tag, "_dwait"}, dwait, 1);
    chk({tag, "_iload"}, iload, 0);
    chk({tag, "_dload"}, dload, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  function automatic vec_t mk(input int kind, input logic [31:0] ia, da, dd, ird, drd,
                              input int lat, input logic fd, input int ff, input int tt);
    vec_t v;
    v.kind = kind; v.ia = ia; v.da = da; v.dd = dd; v.ird = ird; v.drd = drd; v.lat = lat;
    v.exp_first_d = fd; v.exp_first = ff; v.exp_total = tt;
    v.exp_iload = ird; v.exp_dload = drd;
    return v;
  endfunction

  // Reference model: dcache is served first whenever it asks; each grant costs one idle
  // cycle plus lat+1 strobe cycles; a second requester waits for the first to finish.
  function automatic vec_t model_vec(input int kind, input logic [31:0] ia, da, dd, ird, drd,
                                     input int lat);
    bit has_i, has_d;
    has_d = (kind != 0);
    has_i = (kind == 0) || (kind >= 4);
    return mk(kind, ia, da, dd, ird, drd, lat, has_d, lat + 2,
              (has_i && has_d) ? 2 * (lat + 2) : lat + 2);
  endfunction

  // ---------------- driver ----------------
  task automatic run_txn(input vec_t v);
    bit   has_i, has_d, wr, strobe, ack_i, ack_d, drop_i, drop_d;
    int   cyc, act, first_at, last_at;
    exp_t e;
    has_d = (v.kind != 0);
    has_i = (v.kind == 0) || (v.kind >= 4);
    wr    = (v.kind == 2) || (v.kind == 3) || (v.kind == 5);
    exp_q.delete();
    if (has_d) begin
      e.is_d = 1'b1; e.wr = wr; e.addr = v.da; e.data = wr ? v.dd : 32'd0; e.load = v.exp_dload;
      exp_q.push_back(e);
    end
    if (has_i) begin
      e.is_d = 1'b0; e.wr = 1'b0; e.addr = v.ia; e.data = 32'd0; e.load = v.exp_iload;
      exp_q.push_back(e);
    end
    @(posedge CLK); #1;
    iREN   = has_i;
    iaddr  = v.ia;
    dREN   = (v.kind == 1) || (v.kind == 3) || (v.kind == 4);
    dWEN   = wr;
    daddr  = v.da;
    dstore = v.dd;
    cyc = 0; act = 0; first_at = -1; last_at = -1;
    while (exp_q.size() != 0 && cyc < BUDGET) begin
      drop_i = 1'b0; drop_d = 1'b0;
      e = exp_q[0];
      #1;
      strobe = ramREN | ramWEN;
      if (strobe) begin
        chk("ram_addr", ramaddr, e.addr);
        chk("ram_wen", ramWEN, e.wr);
        chk("ram_ren", ramREN, !e.wr);
        chk("ram_store", ramstore, e.data);
        act++;
        ram_ready = (act > v.lat);
        ramload   = (ramaddr == v.da) ? v.drd : v.ird;
      end else begin
        chk("idle_ramaddr", ramaddr, 0);
        chk("idle_ramstore", ramstore, 0);
        ram_ready = 1'($urandom_range(0, 1));
        ramload   = $urandom();
      end
      #1;
      ack_i = !iwait;
      ack_d = !dwait;
      chk("ack_when_ready", ack_i | ack_d, strobe & ram_ready);
      chk("single_ack", ack_i & ack_d, 0);
      if (ack_i | ack_d) begin
        chk("ack_who", ack_d, e.is_d);
        if (first_at < 0) begin
          first_at = cyc + 1;
          chk("first_who", ack_d, v.exp_first_d);
        end
        last_at = cyc + 1;
        if (ack_i) chk("iload", iload, e.load);
        else if (!e.wr) chk("dload", dload, e.load);
        void'(exp_q.pop_front());
        act = 0;
        drop_i = ack_i;
        drop_d = ack_d;
      end else begin
        chk("loads_zero", iload | dload, 0);
      end
      @(posedge CLK); #1;
      ram_ready = 1'b0;
      if (drop_i) iREN = 1'b0;
      if (drop_d) begin dREN = 1'b0; dWEN = 1'b0; end
      cyc++;
    end
    chk("txn_done", exp_q.size(), 0);
    chk("first_ack_cycles", first_at, v.exp_first);
    chk("total_cycles", last_at, v.exp_total);
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ram_ready = 1'b0;
  endtask

  // ---------------- test ----------------
  vec_t tbl[6];
  vec_t rv;
  int   n_acks, n_i;

  initial begin
    tbl[0] = mk(0, 32'h0000_0040, 32'h8000_0000, 32'h0, 32'hDEAD_BEEF, 32'h0, 1, 1'b0, 3, 3);
    tbl[1] = mk(5, 32'h0000_0044, 32'h0000_0080, 32'h1234_5678, 32'h0BAD_F00D, 32'h0, 0, 1'b1, 2, 4);
    tbl[2] = mk(1, 32'h0000_0050, 32'h0000_0100, 32'h0, 32'h0, 32'hCAFE_F00D, 2, 1'b1, 4, 4);
    tbl[3] = mk(3, 32'h0000_0054, 32'h0000_0104, 32'hA5A5_A5A5, 32'h0, 32'h0, 1, 1'b1, 3, 3);
    tbl[4] = mk(0, 32'h0000_0048, 32'h8000_0004, 32'h0, 32'h1357_9BDF, 32'h0, 3, 1'b0, 5, 5);
    tbl[5] = mk(4, 32'h0000_004C, 32'h0000_0108, 32'h0, 32'h1111_2222, 32'h3333_4444, 1, 1'b1, 3, 6);

    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
    repeat (2) @(posedge CLK);
    #2;
    chk_reset_vals("reset");
    RST = 1'b0;

    for (int k = 0; k < 6; k++) run_txn(tbl[k]);

    // Reset held for two cycles in the middle of a dcache grant.
    @(posedge CLK); #1;
    dREN = 1'b1; daddr = 32'h0000_0200;
    @(posedge CLK); #2;
    chk("rst_pre_grant", ramREN, 1);
    RST = 1'b1;
    repeat (2) begin
      @(posedge CLK); #2;
      chk_reset_vals("rst_mid");
    end
    RST = 1'b0; dREN = 1'b0;
    @(posedge CLK); #2;
    chk_reset_vals("rst_after");

    // Abort: dcache withdraws before the RAM completes.
    @(posedge CLK); #1;
    dREN = 1'b1; daddr = 32'h0000_0300;
    @(posedge CLK); #2;
    chk("abort_granted", ramREN, 1);
    #7;
    dREN = 1'b0; ram_ready = 1'b1;
    #1;
    chk("abort_ren_drop", ramREN, 0);
    chk("abort_wen_drop", ramWEN, 0);
    chk("abort_no_ack", dwait, 1);
    @(posedge CLK); #1;
    ram_ready = 1'b0;
    #1;
    chk("abort_idle", dbg_state, 0);
    chk("abort_idle_dwait", dwait, 1);
    run_txn(tbl[2]);

    // Sustained traffic from both caches, RAM always ready.
    @(posedge CLK); #1;
    iREN = 1'b1; iaddr = 32'h0000_0500;
    dREN = 1'b1; dWEN = 1'b0; daddr = 32'h0000_0600;
    ram_ready = 1'b1; ramload = 32'h0000_7777;
    n_acks = 0; n_i = 0;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (!iwait || !dwait) begin
        chk("streak_who", !iwait, FAIR ? ((n_acks % (MAX + 1)) == MAX) : 1'b0);
        n_acks++;
        if (!iwait) n_i++;
      end
      @(posedge CLK); #1;
    end
    chk("streak_acks", n_acks, 25);
    chk("streak_iacks", n_i, FAIR ? (25 / (MAX + 1)) : 0);
    iREN = 1'b0; dREN = 1'b0; ram_ready = 1'b0;
    repeat (2) @(posedge CLK);

    // Random transactions against the reference model.
    for (int r = 0; r < 40; r++) begin
      rv = model_vec($urandom_range(0, 5),
                     {1'b0, 31'($urandom())}, {1'b1, 31'($urandom())},
                     $urandom(), $urandom(), $urandom(), $urandom_range(0, 3));
      run_txn(rv);
    end

    repeat (2) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
